// File: rtl/dmem_responder.sv
// dmem_responder: target end of the CPU data request/response handshake.
// It accepts one word request at a time (a read or a byte-masked write),
// waits a fixed number of cycles, performs the access, and then holds a
// registered response until the CPU takes it.
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  CPU presents a request
//   o_req_ready  a request can be accepted this cycle (IDLE only)
//   i_req_we     1 = write, 0 = read
//   i_req_addr   byte address
//   i_req_wdata  write data
//   i_req_be     byte enables for writes
//   o_rsp_valid  response available (RESP)
//   i_rsp_ready  CPU accepts the response
//   o_rsp_rdata  read data (0 for writes and errors)
//   o_rsp_err    request was misaligned or out of range
//
// State  | meaning
// IDLE   | ready for a request
// WAIT   | request latched, wait counter running down
// RESP   | response registered, held until i_rsp_ready
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [2**ADDR_W];

  logic              w_accept;
  logic              w_access;
  logic              w_err;
  logic [ADDR_W-1:0] w_idx;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // Misaligned, or any address bit above the storage window set.
  assign w_err    = (r_addr[1:0] != 2'b00) || (|r_addr[31:ADDR_W+2]);
  assign w_idx    = r_addr[ADDR_W+1:2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid)   w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready)   w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= LAT_C;
        r_we    <= i_req_we;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_be    <= i_req_be;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (r_we || w_err) ? 32'd0 : r_mem[w_idx];
      end else if ((r_state == S_RESP) && i_rsp_ready) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // Storage has no reset; a reset in WAIT drops the state, so the pending
  // write never reaches this block.
  always_ff @(posedge i_clk) begin
    if (w_access && r_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance u0 uses LATENCY=2, instance
// u1 uses LATENCY=0. Request inputs are shared; sel steers valid/ready and
// picks which instance's outputs are observed.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid & ~sel), .o_req_ready(a_req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_be(req_be),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready & ~sel),
    .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid & sel), .o_req_ready(b_req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_be(req_be),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready & sel),
    .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err)
  );

  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction: present, accept, wait for response, optionally
  // stall the response for `hold` cycles, then hand it off.
  task automatic xact(input string tag, input logic s, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    logic [31:0] rd0;
    @(posedge clk); #1;
    sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(m_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!m_rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, m_rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(m_rsp_err), 32'(exp_err));
    rd0 = m_rsp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(m_rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, m_rsp_rdata, rd0);
      chk({tag, "_hold_rdy"}, 32'(m_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(m_rsp_valid), 32'd0);
    chk({tag, "_post_rdy"}, 32'(m_req_ready), 32'd1);
    chk({tag, "_post_rdata"}, m_rsp_rdata, 32'd0);
  endtask

  initial begin
    int acc_idx [$];

    #12;
    chk("rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rdata", a_rsp_rdata, 32'd0);
    chk("rst_err", 32'(a_rsp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    xact("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 3, 32'h0, 0);
    xact("rd10", 0, 0, 32'h10, 32'h0, 4'b0000, 0, 3, 32'hDEADBEEF, 0);
    xact("wr10p", 0, 1, 32'h10, 32'h11223344, 4'b0101, 0, 3, 32'h0, 0);
    xact("rd10p", 0, 0, 32'h10, 32'h0, 4'b0000, 0, 3, 32'hDE22BE44, 0);
    xact("wr10z", 0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 3, 32'h0, 0);
    xact("rd10z", 0, 0, 32'h10, 32'h0, 4'b1111, 0, 3, 32'hDE22BE44, 0);
    xact("rd13", 0, 0, 32'h13, 32'h0, 4'b0000, 0, 3, 32'h0, 1);
    xact("wr0", 0, 1, 32'h0, 32'h0BADF00D, 4'b1111, 0, 3, 32'h0, 0);
    xact("wr1000", 0, 1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 0, 3, 32'h0, 1);
    xact("rd0", 0, 0, 32'h0, 32'h0, 4'b0000, 0, 3, 32'h0BADF00D, 0);
    xact("bp", 0, 0, 32'h10, 32'h0, 4'b0000, 5, 3, 32'hDE22BE44, 0);

    xact("l0_wr4", 1, 1, 32'h4, 32'hA5A5A5A5, 4'b1111, 0, 1, 32'h0, 0);
    xact("l0_rd4", 1, 0, 32'h4, 32'h0, 4'b0000, 0, 1, 32'hA5A5A5A5, 0);

    // Back-to-back: valid and rsp_ready held high; accepts must be
    // LATENCY+3 = 5 cycles apart.
    @(posedge clk); #1;
    sel = 0; req_we = 0; req_addr = 32'h10; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (req_valid && m_req_ready) acc_idx.push_back(i);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("b2b_count", 32'(acc_idx.size()), 32'd3);
    if (acc_idx.size() >= 2) chk("b2b_gap", 32'(acc_idx[1] - acc_idx[0]), 32'd5);
    else chk("b2b_gap", 32'hFFFFFFFF, 32'd5);
    repeat (3) @(posedge clk);

    // Reset in WAIT on a write must drop the write.
    xact("wr20", 0, 1, 32'h20, 32'hCAFEF00D, 4'b1111, 0, 3, 32'h0, 0);
    @(posedge clk); #1;
    sel = 0; req_we = 1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_be = 4'b1111; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_in_wait", 32'(a_req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req_ready", 32'(a_req_ready), 32'd1);
    chk("mid_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("mid_rdata", a_rsp_rdata, 32'd0);
    chk("mid_err", 32'(a_rsp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    xact("rd20", 0, 0, 32'h20, 32'h0, 4'b0000, 0, 3, 32'hCAFEF00D, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the CPU's memory-access stage. It is the target end of the data request/response handshake.
- Accepts one word request at a time (read or byte-masked write) and models a fixed number of wait states.
- Returns a registered response that is held until the CPU takes it.
- Replaces the combinational data memory. It lets the pipeline be verified against realistic, stalling memory timing.

Parameters:
ADDR_W, 10, word-address width; storage depth is 2**ADDR_W words of 32 bits.
LATENCY, 2, wait-state cycles between acceptance and access (0..15 legal).

Ports:
CLK  input  1  clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-low reset.
req_valid  input  1  CPU presents a request.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1=write, 0=read.
req_addr  input  32  byte address.
req_wdata  input  32  write data.
req_be  input  4  byte enables for writes; bit i selects wdata[8i+7:8i].
rsp_valid  output  1  response available.
rsp_ready  input  1  CPU accepts the response.
rsp_rdata  output  32  read data (0 for writes and errors).
rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Storage array is not cleared.
  - A request in WAIT at reset is dropped; its write is never performed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - At an edge with req_valid=1, the request is accepted. Latch we/addr/wdata/be, load cnt=LATENCY, go to WAIT.
  - req_ready is 0 in WAIT and RESP. Requests presented then are not accepted, and the CPU must hold them.
- WAIT:
  - If cnt!=0: cnt decrements.
  - If cnt==0, on that edge the access is performed, the response is registered, and state goes to RESP.
  - Net latency: the access edge is acceptance edge + LATENCY + 1. rsp_valid is high from that edge onward.
- Access rules:
  - err when req_addr[1:0]!=0, or when any bit of req_addr[31:ADDR_W+2] is 1. On err: no storage change, rsp_rdata=0, rsp_err=1.
  - Read: rsp_rdata = mem[req_addr[ADDR_W+1:2]] (full word, be ignored), rsp_err=0.
  - Write: only bytes with be bit set are updated. be=0000 is legal and is a no-op with err=0. rsp_rdata=0.
- RESP:
  - rsp_valid=1. rsp_rdata/rsp_err are stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid=0, rsp_rdata=0, rsp_err=0, go to IDLE.
  - rsp_ready=1 arriving early (before RESP) has no effect.
- Throughput: at most one request per LATENCY+3 cycles. There is a mandatory IDLE cycle after each response, with no accept in the same cycle as the response handshake.
- Ordering: a read issued after a write to the same word returns the merged written data.

Test Plan:
- Reset, LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, be 1111 -> rsp_valid 3 edges after accept, rsp_err=0, rsp_rdata=0. Then read 0x10 -> rsp_rdata=0xDEADBEEF.
- Partial write to 0x10: be 0101, wdata 0x11223344 after the above -> later read returns 0xDE22BE44. Write with be 0000 -> read unchanged.
- Error cases:
  - Read 0x13 -> rsp_err=1, rsp_rdata=0.
  - Write 0x1000 (ADDR_W=10) -> rsp_err=1, and a read of 0x0 is unchanged.
- Response backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0 throughout. Raise rsp_ready -> next cycle IDLE with req_ready=1.
- Timing edge cases:
  - LATENCY=0: read accepted at edge A -> rsp_valid high after edge A+1.
  - Back-to-back req_valid held high -> second accept no earlier than one cycle after the first response handshake.
- Reset mid-operation: assert Reset=0 asynchronously while in WAIT on a write to 0x20 -> outputs go to reset values immediately. A subsequent read of 0x20 returns the prior contents (write not performed).
